// File: rtl/playbus_blkcopy.sv
// Block-copy sequencer for the play bus: walks a block of addresses, enabling one
// source and pulsing one sink strobe per transfer, with an optional dwell in END.
module playbus_blkcopy #(
  parameter int unsigned DWELL = 0
) (
  input  logic       CK2HZ,
  input  logic       n_CLR,
  input  logic       GO,
  input  logic [1:0] MODE,
  input  logic [3:0] START,
  input  logic [3:0] LEN,
  output logic [3:0] ADD,
  output logic       n_ROMO,
  output logic       n_RAMO,
  output logic       n_SWBEN,
  output logic       n_RAMW,
  output logic       LEDLTCH,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] St
);

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned MW = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SRC   = 2'd1,
    S_WRITE = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_add;
  logic [AW-1:0]   w_add_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   r_dwell;
  logic [CW-1:0]   w_dwell_nxt;
  logic [MW-1:0]   r_mode;
  logic [MW-1:0]   w_mode_nxt;
  logic            r_ramw;
  logic            w_ramw_nxt;
  logic            r_ledltch;
  logic            w_ledltch_nxt;
  logic            w_active;

  // State and datapath registers; the transfer counter doubles as the latched LEN.
  always_ff @(posedge CK2HZ or negedge n_CLR) begin
    if (!n_CLR) begin
      r_state   <= S_IDLE;
      r_add     <= '0;
      r_cnt     <= '0;
      r_dwell   <= '0;
      r_mode    <= '0;
      r_ramw    <= 1'b0;
      r_ledltch <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_add     <= w_add_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dwell   <= w_dwell_nxt;
      r_mode    <= w_mode_nxt;
      r_ramw    <= w_ramw_nxt;
      r_ledltch <= w_ledltch_nxt;
    end
  end

  // Next-state and next-datapath logic; mode bit 1 selects the LED sink.
  always_comb begin
    w_state_nxt   = r_state;
    w_add_nxt     = r_add;
    w_cnt_nxt     = r_cnt;
    w_dwell_nxt   = r_dwell;
    w_mode_nxt    = r_mode;
    w_ramw_nxt    = r_ramw;
    w_ledltch_nxt = r_ledltch;
    case (r_state)
      S_IDLE: begin
        if (GO) begin
          w_mode_nxt  = MODE;
          w_add_nxt   = START;
          w_cnt_nxt   = LEN;
          w_state_nxt = S_SRC;
        end
      end
      S_SRC: begin
        w_ramw_nxt    = ~r_mode[1];
        w_ledltch_nxt = r_mode[1];
        w_state_nxt   = S_WRITE;
      end
      S_WRITE: begin
        w_ramw_nxt    = 1'b0;
        w_ledltch_nxt = 1'b0;
        w_dwell_nxt   = CW'(DWELL);
        w_state_nxt   = S_END;
      end
      S_END: begin
        if (r_dwell != '0) begin
          w_dwell_nxt = r_dwell - CW'(1);
        end else if (r_cnt != '0) begin
          w_add_nxt   = r_add + AW'(1);
          w_cnt_nxt   = r_cnt - CW'(1);
          w_state_nxt = S_SRC;
        end else if (!GO) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state; ADD follows START only while idle.
  assign w_active = (r_state != S_IDLE);
  assign ADD      = w_active ? r_add : START;
  assign n_ROMO   = ~(w_active && !r_mode[0]);
  assign n_SWBEN  = ~(w_active && (r_mode == MW'(1)));
  assign n_RAMO   = ~(w_active && (r_mode == MW'(3)));
  assign n_RAMW   = ~r_ramw;
  assign LEDLTCH  = r_ledltch;
  assign BUSY     = w_active;
  assign DONE     = (r_state == S_END) && (r_dwell == '0) && (r_cnt == '0);
  assign St       = r_state;

endmodule

// File: tb/tb_playbus_blkcopy.sv
// Bench for playbus_blkcopy: two instances (DWELL 0 and 4) share stimulus and are
// compared every cycle against a timeline model, plus literal spot checks.
module tb_playbus_blkcopy;

  logic       clk;
  logic       n_clr;
  logic       go;
  logic [1:0] mode;
  logic [3:0] start;
  logic [3:0] len;

  logic [3:0] add_o   [2];
  logic       romo_o  [2];
  logic       ramo_o  [2];
  logic       swben_o [2];
  logic       ramw_o  [2];
  logic       led_o   [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic [1:0] st_o    [2];

  int n_tests = 0;
  int n_fail  = 0;

  playbus_blkcopy #(.DWELL(0)) u_dut0 (
    .CK2HZ(clk), .n_CLR(n_clr), .GO(go), .MODE(mode), .START(start), .LEN(len),
    .ADD(add_o[0]), .n_ROMO(romo_o[0]), .n_RAMO(ramo_o[0]), .n_SWBEN(swben_o[0]),
    .n_RAMW(ramw_o[0]), .LEDLTCH(led_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0]),
    .St(st_o[0]));

  playbus_blkcopy #(.DWELL(4)) u_dut4 (
    .CK2HZ(clk), .n_CLR(n_clr), .GO(go), .MODE(mode), .START(start), .LEN(len),
    .ADD(add_o[1]), .n_ROMO(romo_o[1]), .n_RAMO(ramo_o[1]), .n_SWBEN(swben_o[1]),
    .n_RAMW(ramw_o[1]), .LEDLTCH(led_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1]),
    .St(st_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a sequence is a timeline of (LEN+1)*(3+D) cycles indexed by m_t.
  bit       m_busy  [2];
  int       m_t     [2];
  bit [1:0] m_mode  [2];
  bit [3:0] m_start [2];
  bit [3:0] m_len   [2];

  function automatic int dw(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic int total(input int i);
    return (int'(m_len[i]) + 1) * (3 + dw(i));
  endfunction

  always @(posedge clk or negedge n_clr) begin
    for (int i = 0; i < 2; i++) begin
      if (!n_clr) begin
        m_busy[i] <= 1'b0;
        m_t[i]    <= 0;
        m_mode[i] <= 2'd0;
      end else if (!m_busy[i]) begin
        if (go) begin
          m_busy[i]  <= 1'b1;
          m_t[i]     <= 0;
          m_mode[i]  <= mode;
          m_start[i] <= start;
          m_len[i]   <= len;
        end
      end else if (m_t[i] < total(i) - 1) begin
        m_t[i] <= m_t[i] + 1;
      end else if (!go) begin
        m_busy[i] <= 1'b0;
      end
    end
  end

  // Expected {St, ADD, n_ROMO, n_RAMO, n_SWBEN, n_RAMW, LEDLTCH, BUSY, DONE}.
  function automatic logic [12:0] expect_vec(input int i);
    int p, k, pos;
    logic [1:0] e_st;
    logic [3:0] e_add;
    if (!m_busy[i]) return {2'd0, start, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    p     = 3 + dw(i);
    k     = m_t[i] / p;
    pos   = m_t[i] % p;
    e_st  = (pos == 0) ? 2'd1 : (pos == 1) ? 2'd2 : 2'd3;
    e_add = 4'((int'(m_start[i]) + k) % 16);
    return {e_st, e_add,
            1'(!(m_mode[i] == 2'd0 || m_mode[i] == 2'd2)),
            1'(!(m_mode[i] == 2'd3)),
            1'(!(m_mode[i] == 2'd1)),
            1'(!(pos == 1 && m_mode[i] < 2'd2)),
            1'(pos == 1 && m_mode[i] >= 2'd2),
            1'b1,
            1'(m_t[i] == total(i) - 1)};
  endfunction

  // Per-cycle compare against the model plus the structural invariants.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [12:0] act, exp_v;
      int nlow;
      act   = {st_o[i], add_o[i], romo_o[i], ramo_o[i], swben_o[i], ramw_o[i],
               led_o[i], busy_o[i], done_o[i]};
      exp_v = expect_vec(i);
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_vec dut%0d t=%0t actual=%b required=%b", i, $time, act, exp_v);
      end
      nlow = int'(!romo_o[i]) + int'(!ramo_o[i]) + int'(!swben_o[i]);
      n_tests++;
      if (nlow > 1 || (!ramo_o[i] && !ramw_o[i]) || (!ramw_o[i] && led_o[i]) ||
          (busy_o[i] !== (st_o[i] != 2'd0))) begin
        n_fail++;
        $display("FAIL invariant dut%0d t=%0t enables_low=%0d n_RAMO=%b n_RAMW=%b LEDLTCH=%b BUSY=%b St=%0d required=ok",
                 i, $time, nlow, ramo_o[i], ramw_o[i], led_o[i], busy_o[i], st_o[i]);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp_v);
    end
  endtask

  task automatic go_pulse(input logic [1:0] m, input logic [3:0] s, input logic [3:0] l);
    @(posedge clk); #2;
    mode = m; start = s; len = l; go = 1'b1;
    @(posedge clk); #2;
    go = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (!busy_o[0] && !busy_o[1]) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
  endtask

  initial begin
    int cnt, cnt4;
    n_clr = 1'b0; go = 1'b0; mode = 2'd0; start = 4'd0; len = 4'd0;
    #1;
    check("reset_st", int'(st_o[0]), 0);
    check("reset_nramw", int'(ramw_o[0]), 1);
    check("reset_busy", int'(busy_o[1]), 0);
    repeat (2) @(posedge clk);
    #2 n_clr = 1'b1;

    // ROM->RAM, 3 transfers from address 3
    go_pulse(2'd0, 4'd3, 4'd2);
    @(negedge clk); #1;
    check("r31_src_st", int'(st_o[0]), 1);
    check("r31_src_add", int'(add_o[0]), 3);
    check("r31_romo", int'(romo_o[0]), 0);
    @(negedge clk); #1;
    check("r31_write_nramw", int'(ramw_o[0]), 0);
    repeat (7) @(negedge clk); #1;
    check("r31_done", int'(done_o[0]), 1);
    check("r31_last_add", int'(add_o[0]), 5);
    wait_idle("r31");

    // SW->RAM wrapping 14,15,0,1
    go_pulse(2'd1, 4'd14, 4'd3);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (!ramw_o[0]) cnt++;
      if (c == 0) check("r32_swben", int'(swben_o[0]), 0);
      if (c == 3) check("r32_add15", int'(add_o[0]), 15);
      if (c == 6) check("r32_wrap0", int'(add_o[0]), 0);
      if (c == 9) check("r32_add1", int'(add_o[0]), 1);
    end
    check("r32_pulses", cnt, 4);
    wait_idle("r32");

    // RAM->LED single transfer, GO held, dwell instance holds END 5 cycles
    @(posedge clk); #2;
    mode = 2'd3; start = 4'd2; len = 4'd0; go = 1'b1;
    @(posedge clk); #2;
    cnt4 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (led_o[1]) cnt4++;
      if (c == 5) check("r33_dwell_notdone", int'(done_o[1]), 0);
      if (c == 6) check("r33_dwell_done", int'(done_o[1]), 1);
    end
    check("r33_led_pulses", cnt4, 1);
    check("r33_hold_st", int'(st_o[1]), 3);
    check("r33_hold_done", int'(done_o[1]), 1);
    @(posedge clk); #2;
    go = 1'b0;
    @(negedge clk); #1;
    check("r33_still_end", int'(st_o[1]), 3);
    @(negedge clk); #1;
    check("r33_idle", int'(st_o[1]), 0);
    check("r33_idle0", int'(st_o[0]), 0);

    // ROM->LED, inputs changed during transfer 2 must be ignored
    go_pulse(2'd2, 4'd5, 4'd3);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (led_o[0]) cnt++;
      if (c == 3) begin
        mode = 2'd1; start = 4'd9; len = 4'd0;
      end
      if (c == 6) begin
        check("r34_add", int'(add_o[0]), 7);
        check("r34_romo", int'(romo_o[0]), 0);
        check("r34_swben", int'(swben_o[0]), 1);
      end
    end
    check("r34_led_pulses", cnt, 4);
    wait_idle("r34");

    // Reset during WRITE aborts immediately, then restart with GO held
    go_pulse(2'd0, 4'd8, 4'd3);
    @(negedge clk);
    @(negedge clk); #1;
    check("r35_in_write", int'(ramw_o[0]), 0);
    go = 1'b1;
    #1 n_clr = 1'b0;
    #1;
    check("r35_nramw0", int'(ramw_o[0]), 1);
    check("r35_st0", int'(st_o[0]), 0);
    check("r35_nramw4", int'(ramw_o[1]), 1);
    check("r35_st4", int'(st_o[1]), 0);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (!ramw_o[0] || !ramw_o[1]) cnt++;
    end
    check("r35_no_strobe", cnt, 0);
    @(posedge clk); #2;
    n_clr = 1'b1;
    @(negedge clk); #1;
    check("r30_pre_edge", int'(st_o[0]), 0);
    @(negedge clk); #1;
    check("r30_started", int'(st_o[0]), 1);
    check("r30_add", int'(add_o[0]), 8);
    go = 1'b0;
    wait_idle("r30");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
